// File: rtl/jtopl_eg_pkg.sv
// Shared constants for the envelope-generator pipeline.
package jtopl_eg_pkg;

  // Operator slots visited per round.
  localparam int SLOTS = 18;

  // Maximum attenuation (silence).
  localparam logic [9:0] EG_MAX = 10'h3FF;

  // Envelope phase encoding.
  typedef enum logic [2:0] {
    RELEASE = 3'b000,
    ATTACK  = 3'b001,
    DECAY   = 3'b010,
    HOLD    = 3'b100
  } eg_state_e;

endpackage

// File: rtl/jtopl_eg_ring.sv
// W-bit wide, D-deep clock-enabled shift register used as circular
// per-slot storage. A value written at din reappears at dout exactly
// D enabled cycles later.
module jtopl_eg_ring #(
  parameter int           W       = 1,
  parameter int           D       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] tap_reg [D];

  // Shift one position per enabled cycle; reset fills every tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) tap_reg[i] <= RST_VAL;
    end else if (cen) begin
      tap_reg[0] <= din;
      for (int i = 1; i < D; i++) tap_reg[i] <= tap_reg[i-1];
    end
  end

  assign dout = tap_reg[D-1];

endmodule

// File: rtl/jtopl_eg_pipe.sv
// Envelope-generator pipeline: per-slot state rings, key-edge detection,
// global envelope counter and the registers between combinational
// envelope stages I..IV (the stages themselves live one level up).
module jtopl_eg_pipe
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = jtopl_eg_pkg::SLOTS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        zero,
  input  logic        keyon,
  // stage-I slot parameters
  input  logic        en_sus,
  input  logic [3:0]  arate,
  input  logic [3:0]  drate,
  input  logic [3:0]  rrate,
  input  logic [3:0]  sl,
  // stage-II slot parameters
  input  logic [3:0]  keycode,
  input  logic        ks,
  // stage-IV slot parameters
  input  logic [6:0]  tl,
  input  logic        amsen,
  input  logic        ams,
  input  logic [6:0]  lfo_mod,
  // stage I
  output logic        s1_keyon_now,
  output logic        s1_keyoff_now,
  output logic [2:0]  s1_state,
  output logic [9:0]  s1_eg,
  input  logic [4:0]  s1_base_rate,
  input  logic [2:0]  s1_state_next,
  input  logic        s1_pg_rst,
  // stage II
  output logic        s2_attack,
  output logic [4:0]  s2_rate_in,
  output logic        s2_cnt_in,
  output logic [14:0] eg_cnt,
  input  logic        s2_cnt_lsb,
  input  logic        s2_step,
  input  logic [5:0]  s2_rate_out,
  input  logic        s2_sum_up,
  // stage III
  output logic        s3_attack,
  output logic        s3_step,
  output logic [5:1]  s3_rate,
  output logic [9:0]  s3_eg,
  output logic        s3_sum_up,
  input  logic [9:0]  s3_eg_out,
  // stage IV
  output logic [9:0]  s4_eg,
  input  logic [9:0]  s4_eg_out,
  // results
  output logic        pg_rst_II,
  output logic [9:0]  eg_V
);

  // Slot parameters are consumed by the stage block wired alongside this
  // module; rate_out[0] is not needed past stage II.
  logic params_unused;
  assign params_unused = ^{en_sus, arate, drate, rrate, sl, keycode, ks,
                           tl, amsen, ams, lfo_mod, s2_rate_out[0]};

  logic prev_key;

  // Previous key bit per slot, rewritten on every visit.
  jtopl_eg_ring #(.W(1), .D(SLOTS), .RST_VAL(1'b0)) u_prev_key (
    .clk(clk), .rst(rst), .cen(cen), .din(keyon), .dout(prev_key)
  );

  // Phase per slot, written with the stage-I decision.
  jtopl_eg_ring #(.W(3), .D(SLOTS), .RST_VAL(RELEASE)) u_state (
    .clk(clk), .rst(rst), .cen(cen), .din(s1_state_next), .dout(s1_state)
  );

  // Attenuation is written two stages after stage I, so the ring is two
  // taps shorter to bring it back to stage I on the slot's next visit.
  jtopl_eg_ring #(.W(10), .D(SLOTS-2), .RST_VAL(EG_MAX)) u_eg (
    .clk(clk), .rst(rst), .cen(cen), .din(s3_eg_out), .dout(s1_eg)
  );

  // Counter LSB per slot, written and read back at stage II.
  jtopl_eg_ring #(.W(1), .D(SLOTS), .RST_VAL(1'b0)) u_cnt_lsb (
    .clk(clk), .rst(rst), .cen(cen), .din(s2_cnt_lsb), .dout(s2_cnt_in)
  );

  assign s1_keyon_now  = keyon & ~prev_key;
  assign s1_keyoff_now = ~keyon & prev_key;

  logic [14:0] eg_cnt_reg;
  logic        s2_attack_reg;
  logic [4:0]  s2_rate_in_reg;
  logic [9:0]  s2_eg_reg;
  logic        pg_rst_reg;
  logic        s3_attack_reg;
  logic        s3_step_reg;
  logic [5:1]  s3_rate_reg;
  logic [9:0]  s3_eg_reg;
  logic        s3_sum_up_reg;
  logic [9:0]  s4_eg_reg;
  logic [9:0]  eg_v_reg;

  // Global envelope counter: advances once per round on the slot-0 marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      eg_cnt_reg <= '0;
    end else if (cen && zero) begin
      eg_cnt_reg <= eg_cnt_reg + 15'd1;
    end
  end

  // Inter-stage registers carrying each slot from stage I through to eg_V.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_attack_reg  <= 1'b0;
      s2_rate_in_reg <= '0;
      s2_eg_reg      <= EG_MAX;
      pg_rst_reg     <= 1'b0;
      s3_attack_reg  <= 1'b0;
      s3_step_reg    <= 1'b0;
      s3_rate_reg    <= '0;
      s3_eg_reg      <= EG_MAX;
      s3_sum_up_reg  <= 1'b0;
      s4_eg_reg      <= EG_MAX;
      eg_v_reg       <= EG_MAX;
    end else if (cen) begin
      s2_attack_reg  <= (s1_state_next == ATTACK);
      s2_rate_in_reg <= s1_base_rate;
      s2_eg_reg      <= s1_eg;
      pg_rst_reg     <= s1_pg_rst;
      s3_attack_reg  <= s2_attack_reg;
      s3_step_reg    <= s2_step;
      s3_rate_reg    <= s2_rate_out[5:1];
      s3_eg_reg      <= s2_eg_reg;
      s3_sum_up_reg  <= s2_sum_up;
      s4_eg_reg      <= s3_eg_out;
      eg_v_reg       <= s4_eg_out;
    end
  end

  assign eg_cnt     = eg_cnt_reg;
  assign s2_attack  = s2_attack_reg;
  assign s2_rate_in = s2_rate_in_reg;
  assign pg_rst_II  = pg_rst_reg;
  assign s3_attack  = s3_attack_reg;
  assign s3_step    = s3_step_reg;
  assign s3_rate    = s3_rate_reg;
  assign s3_eg      = s3_eg_reg;
  assign s3_sum_up  = s3_sum_up_reg;
  assign s4_eg      = s4_eg_reg;
  assign eg_V       = eg_v_reg;

endmodule

// File: tb/tb_jtopl_eg_pipe.sv
// Bench for jtopl_eg_pipe. The bench plays the combinational stage block:
// every slot entering stage I gets a "journey" record holding the stub
// answers for stages I..IV and the values the pipeline must present.
// Records are queued at stage I and retired when eg_V is due.
module tb_jtopl_eg_pipe;
  import jtopl_eg_pkg::*;

  localparam int NS = 18;

  logic        clk = 1'b0;
  logic        rst, cen, zero, keyon;
  logic        en_sus, ks, amsen, ams;
  logic [3:0]  arate, drate, rrate, sl, keycode;
  logic [6:0]  tl, lfo_mod;
  logic        s1_keyon_now, s1_keyoff_now;
  logic [2:0]  s1_state;
  logic [9:0]  s1_eg;
  logic [4:0]  s1_base_rate;
  logic [2:0]  s1_state_next;
  logic        s1_pg_rst;
  logic        s2_attack;
  logic [4:0]  s2_rate_in;
  logic        s2_cnt_in;
  logic [14:0] eg_cnt;
  logic        s2_cnt_lsb, s2_step, s2_sum_up;
  logic [5:0]  s2_rate_out;
  logic        s3_attack, s3_step, s3_sum_up;
  logic [5:1]  s3_rate;
  logic [9:0]  s3_eg, s3_eg_out, s4_eg, s4_eg_out;
  logic        pg_rst_II;
  logic [9:0]  eg_V;

  always #5 clk = ~clk;

  jtopl_eg_pipe dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .keyon(keyon),
    .en_sus(en_sus), .arate(arate), .drate(drate), .rrate(rrate), .sl(sl),
    .keycode(keycode), .ks(ks), .tl(tl), .amsen(amsen), .ams(ams), .lfo_mod(lfo_mod),
    .s1_keyon_now(s1_keyon_now), .s1_keyoff_now(s1_keyoff_now),
    .s1_state(s1_state), .s1_eg(s1_eg),
    .s1_base_rate(s1_base_rate), .s1_state_next(s1_state_next), .s1_pg_rst(s1_pg_rst),
    .s2_attack(s2_attack), .s2_rate_in(s2_rate_in), .s2_cnt_in(s2_cnt_in), .eg_cnt(eg_cnt),
    .s2_cnt_lsb(s2_cnt_lsb), .s2_step(s2_step), .s2_rate_out(s2_rate_out), .s2_sum_up(s2_sum_up),
    .s3_attack(s3_attack), .s3_step(s3_step), .s3_rate(s3_rate), .s3_eg(s3_eg),
    .s3_sum_up(s3_sum_up), .s3_eg_out(s3_eg_out),
    .s4_eg(s4_eg), .s4_eg_out(s4_eg_out),
    .pg_rst_II(pg_rst_II), .eg_V(eg_V)
  );

  typedef struct {
    int         slot;
    logic [2:0] st_next;
    logic [4:0] base_rate;
    logic       pg;
    logic [9:0] eg1;
    logic       lsb_exp;
    logic       lsb_out;
    logic       step;
    logic [5:0] rate_out;
    logic       sum_up;
    logic [9:0] s3_out;
    logic [9:0] s4_out;
  } journey_t;

  journey_t    pipe_q[$];
  logic [2:0]  m_state [NS];
  logic        m_prev  [NS];
  logic [9:0]  m_eg    [NS];
  logic        m_lsb   [NS];
  logic        key     [NS];
  logic [14:0] m_cnt;
  int          slot_i;
  logic        fast_zero, force7;
  int          n_pass, n_checks;

  int          obs_slot;
  logic        obs_kon, obs_koff;
  logic [2:0]  obs_state;
  logic [9:0]  obs_eg;

  task automatic do_reset(input int n, input logic cen_v);
    journey_t d;
    rst = 1'b1;
    cen = cen_v;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      m_state[i] = RELEASE; m_prev[i] = 1'b0; m_eg[i] = 10'h3FF; m_lsb[i] = 1'b0;
    end
    m_cnt = '0;
    slot_i = 0;
    d = '{slot: -1, st_next: RELEASE, base_rate: 5'd0, pg: 1'b0, eg1: 10'h3FF,
          lsb_exp: 1'b0, lsb_out: 1'b0, step: 1'b0, rate_out: 6'd0, sum_up: 1'b0,
          s3_out: 10'h3FF, s4_out: 10'h3FF};
    pipe_q.delete();
    repeat (4) pipe_q.push_back(d);
  endtask

  // One clock: drive stage I for the current slot and stages II..IV from
  // the queued journeys, check every pipeline output, then clock.
  task automatic cycle(input logic cen_v);
    journey_t a1, a2, a3, a4, nj;
    int       s;
    logic     exp_kon, exp_koff;
    s  = slot_i;
    a1 = pipe_q[3]; a2 = pipe_q[2]; a3 = pipe_q[1]; a4 = pipe_q[0];
    cen = cen_v; zero = fast_zero | (s == 0); keyon = key[s];
    en_sus = 1'($urandom); arate = 4'($urandom); drate = 4'($urandom);
    rrate = 4'($urandom); sl = 4'($urandom); keycode = 4'($urandom); ks = 1'($urandom);
    tl = 7'($urandom); amsen = 1'($urandom); ams = 1'($urandom); lfo_mod = 7'($urandom);
    s2_cnt_lsb = a1.lsb_out; s2_step = a1.step; s2_rate_out = a1.rate_out; s2_sum_up = a1.sum_up;
    s3_eg_out = a2.s3_out;
    s4_eg_out = a3.s4_out;
    exp_kon  = key[s] & ~m_prev[s];
    exp_koff = ~key[s] & m_prev[s];
    nj.slot      = s;
    nj.st_next   = exp_kon ? ATTACK : (exp_koff ? RELEASE : m_state[s]);
    nj.base_rate = 5'($urandom);
    nj.pg        = exp_kon;
    nj.eg1       = m_eg[s];
    nj.lsb_exp   = m_lsb[s];
    nj.lsb_out   = 1'($urandom);
    nj.step      = 1'($urandom);
    nj.rate_out  = 6'($urandom);
    nj.sum_up    = 1'($urandom);
    nj.s3_out    = (force7 && s == 7) ? 10'h123 : 10'($urandom);
    nj.s4_out    = (force7 && s == 7) ? 10'h055 : 10'($urandom);
    s1_state_next = nj.st_next; s1_base_rate = nj.base_rate; s1_pg_rst = nj.pg;
    #1;
    n_checks++; if (s1_state !== m_state[s]) $display("FAIL s1_state slot %0d: got %h want %h", s, s1_state, m_state[s]); else n_pass++;
    n_checks++; if (s1_eg !== m_eg[s]) $display("FAIL s1_eg slot %0d: got %h want %h", s, s1_eg, m_eg[s]); else n_pass++;
    n_checks++; if (s1_keyon_now !== exp_kon) $display("FAIL keyon_now slot %0d: got %b want %b", s, s1_keyon_now, exp_kon); else n_pass++;
    n_checks++; if (s1_keyoff_now !== exp_koff) $display("FAIL keyoff_now slot %0d: got %b want %b", s, s1_keyoff_now, exp_koff); else n_pass++;
    n_checks++; if (eg_cnt !== m_cnt) $display("FAIL eg_cnt: got %h want %h", eg_cnt, m_cnt); else n_pass++;
    n_checks++; if (pg_rst_II !== a1.pg) $display("FAIL pg_rst_II slot %0d: got %b want %b", a1.slot, pg_rst_II, a1.pg); else n_pass++;
    n_checks++; if (s2_attack !== (a1.st_next == ATTACK)) $display("FAIL s2_attack slot %0d: got %b want %b", a1.slot, s2_attack, a1.st_next == ATTACK); else n_pass++;
    n_checks++; if (s2_rate_in !== a1.base_rate) $display("FAIL s2_rate_in slot %0d: got %h want %h", a1.slot, s2_rate_in, a1.base_rate); else n_pass++;
    n_checks++; if (s2_cnt_in !== a1.lsb_exp) $display("FAIL s2_cnt_in slot %0d: got %b want %b", a1.slot, s2_cnt_in, a1.lsb_exp); else n_pass++;
    n_checks++; if (s3_attack !== (a2.st_next == ATTACK)) $display("FAIL s3_attack slot %0d: got %b want %b", a2.slot, s3_attack, a2.st_next == ATTACK); else n_pass++;
    n_checks++; if (s3_step !== a2.step) $display("FAIL s3_step slot %0d: got %b want %b", a2.slot, s3_step, a2.step); else n_pass++;
    n_checks++; if (s3_rate !== a2.rate_out[5:1]) $display("FAIL s3_rate slot %0d: got %h want %h", a2.slot, s3_rate, a2.rate_out[5:1]); else n_pass++;
    n_checks++; if (s3_sum_up !== a2.sum_up) $display("FAIL s3_sum_up slot %0d: got %b want %b", a2.slot, s3_sum_up, a2.sum_up); else n_pass++;
    n_checks++; if (s3_eg !== a2.eg1) $display("FAIL s3_eg slot %0d: got %h want %h", a2.slot, s3_eg, a2.eg1); else n_pass++;
    n_checks++; if (s4_eg !== a3.s3_out) $display("FAIL s4_eg slot %0d: got %h want %h", a3.slot, s4_eg, a3.s3_out); else n_pass++;
    n_checks++; if (eg_V !== a4.s4_out) $display("FAIL eg_V slot %0d: got %h want %h", a4.slot, eg_V, a4.s4_out); else n_pass++;
    obs_slot = s; obs_kon = s1_keyon_now; obs_koff = s1_keyoff_now; obs_state = s1_state; obs_eg = s1_eg;
    if (cen_v) begin
      pipe_q.push_back(nj);
      void'(pipe_q.pop_front());
      m_prev[s]  = key[s];
      m_state[s] = nj.st_next;
      m_eg[s]    = nj.s3_out;
      m_lsb[s]   = nj.lsb_out;
      if (zero) m_cnt = m_cnt + 15'd1;
      slot_i = (s + 1) % NS;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset(2, 1'b1);
    n_checks++; if (eg_V !== 10'h3FF) $display("FAIL reset eg_V: got %h want 3ff", eg_V); else n_pass++;
    n_checks++; if (eg_cnt !== 15'd0) $display("FAIL reset eg_cnt: got %h want 0", eg_cnt); else n_pass++;
    n_checks++; if (pg_rst_II !== 1'b0) $display("FAIL reset pg_rst_II: got %b want 0", pg_rst_II); else n_pass++;
    for (int i = 0; i < NS; i++) begin
      cycle(1'b1);
      n_checks++; if (obs_state !== RELEASE || obs_eg !== 10'h3FF)
        $display("FAIL reset slot %0d: got state %h eg %h want 0/3ff", obs_slot, obs_state, obs_eg); else n_pass++;
    end
    $display("test_reset done");
  endtask

  task automatic test_key_on;
    int visits = 0, pulses = 0;
    key[0] = 1'b1;
    for (int i = 0; i < 3 * NS; i++) begin
      cycle(1'b1);
      if (obs_slot == 0) begin
        visits++;
        if (obs_kon) pulses++;
        if (visits == 1) begin
          n_checks++; if (pg_rst_II !== 1'b1) $display("FAIL keyon pg_rst_II: got %b want 1", pg_rst_II); else n_pass++;
        end
        if (visits == 2) begin
          n_checks++; if (obs_state !== ATTACK) $display("FAIL keyon next state: got %h want %h", obs_state, ATTACK); else n_pass++;
        end
      end
    end
    n_checks++; if (pulses != 1) $display("FAIL keyon pulses: got %0d want 1", pulses); else n_pass++;
    $display("test_key_on done: %0d visits", visits);
  endtask

  task automatic test_key_off;
    int on_p = 0, off_p = 0;
    key[5] = 1'b1;
    for (int i = 0; i < 3 * NS; i++) begin
      cycle(1'b1);
      if (obs_slot == 5 && obs_kon) on_p++;
    end
    key[5] = 1'b0;
    for (int i = 0; i < 2 * NS; i++) begin
      cycle(1'b1);
      if (obs_slot == 5 && obs_koff) off_p++;
    end
    n_checks++; if (on_p != 1) $display("FAIL keyoff on pulses: got %0d want 1", on_p); else n_pass++;
    n_checks++; if (off_p != 1) $display("FAIL keyoff off pulses: got %0d want 1", off_p); else n_pass++;
    $display("test_key_off done");
  endtask

  task automatic test_toggle;
    int visits = 0;
    key[3] = 1'b1;
    for (int i = 0; i < 5 * NS && visits < 4; i++) begin
      cycle(1'b1);
      if (obs_slot == 3) begin
        visits++;
        n_checks++; if (obs_kon !== (visits % 2 == 1) || obs_koff !== (visits % 2 == 0))
          $display("FAIL toggle visit %0d: got on %b off %b want on %b off %b", visits, obs_kon, obs_koff, visits % 2 == 1, visits % 2 == 0); else n_pass++;
        key[3] = ~key[3];
      end
    end
    n_checks++; if (visits != 4) $display("FAIL toggle visits: got %0d want 4", visits); else n_pass++;
    $display("test_toggle done");
  endtask

  task automatic test_ring_latency;
    force7 = 1'b1;
    for (int i = 0; i < 2 * NS; i++) begin
      cycle(1'b1);
      if (obs_slot == 7) break;
    end
    force7 = 1'b0;
    repeat (3) cycle(1'b1);
    n_checks++; if (eg_V !== 10'h055) $display("FAIL latency eg_V: got %h want 055", eg_V); else n_pass++;
    for (int i = 0; i < 2 * NS; i++) begin
      cycle(1'b1);
      if (obs_slot == 7) break;
    end
    n_checks++; if (obs_eg !== 10'h123) $display("FAIL ring s1_eg slot 7: got %h want 123", obs_eg); else n_pass++;
    $display("test_ring_latency done");
  endtask

  task automatic test_cen_gating;
    logic [9:0]  exp_egv, exp_s4, exp_eg9;
    logic [14:0] exp_cnt;
    for (int i = 0; i < 2 * NS && slot_i != 9; i++) cycle(1'b1);
    exp_egv = pipe_q[0].s4_out;
    exp_s4  = pipe_q[1].s3_out;
    exp_cnt = m_cnt;
    exp_eg9 = m_eg[9];
    fast_zero = 1'b1;
    repeat (10) cycle(1'b0);
    fast_zero = 1'b0;
    n_checks++; if (eg_V !== exp_egv) $display("FAIL gated eg_V: got %h want %h", eg_V, exp_egv); else n_pass++;
    n_checks++; if (s4_eg !== exp_s4) $display("FAIL gated s4_eg: got %h want %h", s4_eg, exp_s4); else n_pass++;
    n_checks++; if (eg_cnt !== exp_cnt) $display("FAIL gated eg_cnt: got %h want %h", eg_cnt, exp_cnt); else n_pass++;
    cycle(1'b1);
    n_checks++; if (obs_eg !== exp_eg9) $display("FAIL resume s1_eg slot 9: got %h want %h", obs_eg, exp_eg9); else n_pass++;
    repeat (NS) cycle(1'b1);
    $display("test_cen_gating done");
  endtask

  task automatic test_counter;
    fast_zero = 1'b1;
    for (int i = 0; i < 40000 && m_cnt != 15'h7FFF; i++) cycle(1'b1);
    n_checks++; if (eg_cnt !== 15'h7FFF) $display("FAIL counter top: got %h want 7fff", eg_cnt); else n_pass++;
    cycle(1'b1);
    n_checks++; if (eg_cnt !== 15'h0000) $display("FAIL counter wrap: got %h want 0000", eg_cnt); else n_pass++;
    fast_zero = 1'b0;
    repeat (NS) cycle(1'b1);
    n_checks++; if (eg_cnt !== 15'h0001) $display("FAIL counter per round: got %h want 0001", eg_cnt); else n_pass++;
    $display("test_counter done");
  endtask

  task automatic test_reset_mid_round;
    int seen0 = 0;
    for (int i = 0; i < 2 * NS && slot_i != 11; i++) cycle(1'b1);
    do_reset(1, 1'b0);
    n_checks++; if (eg_V !== 10'h3FF) $display("FAIL midreset eg_V: got %h want 3ff", eg_V); else n_pass++;
    n_checks++; if (eg_cnt !== 15'd0) $display("FAIL midreset eg_cnt: got %h want 0", eg_cnt); else n_pass++;
    n_checks++; if (s3_eg !== 10'h3FF || s4_eg !== 10'h3FF) $display("FAIL midreset s3/s4_eg: got %h/%h want 3ff", s3_eg, s4_eg); else n_pass++;
    n_checks++; if (s1_state !== RELEASE || s1_eg !== 10'h3FF) $display("FAIL midreset s1: got %h/%h want 0/3ff", s1_state, s1_eg); else n_pass++;
    for (int i = 0; i < 2 * NS; i++) begin
      cycle(1'b1);
      if (obs_slot == 0) begin
        seen0++;
        n_checks++; if (obs_kon !== (seen0 == 1)) $display("FAIL midreset keyon visit %0d: got %b want %b", seen0, obs_kon, seen0 == 1); else n_pass++;
      end
    end
    $display("test_reset_mid_round done");
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    fast_zero = 1'b0; force7 = 1'b0;
    rst = 1'b1; cen = 1'b0; zero = 1'b0; keyon = 1'b0;
    en_sus = 1'b0; ks = 1'b0; amsen = 1'b0; ams = 1'b0;
    arate = '0; drate = '0; rrate = '0; sl = '0; keycode = '0; tl = '0; lfo_mod = '0;
    s1_base_rate = '0; s1_state_next = '0; s1_pg_rst = 1'b0;
    s2_cnt_lsb = 1'b0; s2_step = 1'b0; s2_rate_out = '0; s2_sum_up = 1'b0;
    s3_eg_out = '0; s4_eg_out = '0;
    for (int i = 0; i < NS; i++) key[i] = 1'b0;
    test_reset();
    test_key_on();
    test_key_off();
    test_toggle();
    test_ring_latency();
    test_cen_gating();
    test_counter();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
